// File: rtl/wb_ram512x8_bridge_if.sv
// wb_ram512x8_bridge_if: Wishbone-classic word bus between a master and the byte-SRAM bridge.
interface wb_ram512x8_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [6:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
  modport slave (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack);
endinterface

// File: rtl/wb_ram512x8_bridge.sv
// wb_ram512x8_bridge: serializes Wishbone word accesses into four byte accesses on a 512x8 SRAM.
// Define WB_RAM_WSKIP_EN to make writes visit only the selected byte lanes.
module wb_ram512x8_bridge #(
  parameter int RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_ram512x8_bridge_if.slave   wb,
  output logic                  ram_wen_o,
  output logic [8:0]            ram_adr_o,
  output logic [7:0]            ram_dat_o,
  input  logic [7:0]            ram_dat_i
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  localparam logic [2:0] LAST = 3'(3 + RD_LAT);
  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n, cap;
  logic [6:0]  adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q, rdat;
  logic [8:0]  adr_hold;
  logic [7:0]  dat_hold;
  logic        req, issue;
  assign req = state == IDLE && wb.cyc && wb.stb && !wb.ack;
  assign issue = state == XFER && cnt <= 3'd3;
  assign cap = cnt - 3'(RD_LAT);
  assign wb.ack = state == ACK;
  assign wb.dat_r = rdat;
  // Address/data hold their last issued value outside the issue phase.
  always_comb begin
    ram_adr_o = issue ? {adr_q, cnt[1:0]} : adr_hold;
    ram_dat_o = issue && we_q ? dat_q[8*cnt[1:0] +: 8] : dat_hold;
    ram_wen_o = issue && we_q && sel_q[cnt[1:0]] && wb.cyc && !rst_i;
  end
`ifdef WB_RAM_WSKIP_EN
  logic [2:0] first, nxt;
  always_comb begin
    first = 3'd4;
    nxt = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (wb.sel[i]) first = 3'(i);
      if (sel_q[i] && 3'(i) > cnt) nxt = 3'(i);
    end
  end
  // cnt = 4 is a trailing idle-lane cycle between the last selected lane and ACK.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 3'd1;
    if (state == IDLE) begin
      cnt_n = wb.we ? first : 3'd0;
      if (req) state_n = wb.we && wb.sel == 4'd0 ? ACK : XFER;
    end else if (state == XFER) begin
      if (we_q) cnt_n = nxt;
      if (!wb.cyc) state_n = IDLE;
      else if (we_q ? cnt == 3'd4 : cnt == LAST) state_n = ACK;
    end else state_n = IDLE;
  end
`else
  always_comb begin
    state_n = state;
    cnt_n = cnt + 3'd1;
    if (state == IDLE) begin
      cnt_n = 3'd0;
      if (req) state_n = XFER;
    end else if (state == XFER) begin
      if (!wb.cyc) state_n = IDLE;
      else if (cnt == LAST) state_n = ACK;
    end else state_n = IDLE;
  end
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      adr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      rdat <= '0;
      adr_hold <= '0;
      dat_hold <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      adr_hold <= ram_adr_o;
      dat_hold <= ram_dat_o;
      if (req) begin
        adr_q <= wb.adr;
        we_q <= wb.we;
        sel_q <= wb.sel;
        dat_q <= wb.dat_w;
      end
      // Byte issued RD_LAT cycles ago is now on ram_dat_i; all lanes captured regardless of sel.
      if (state == XFER && !we_q && wb.cyc && cnt >= 3'(RD_LAT)) rdat[8*cap[1:0] +: 8] <= ram_dat_i;
    end
  end
endmodule

// File: tb/tb_wb_ram512x8_bridge.sv
// tb_wb_ram512x8_bridge: scoreboard bench for RD_LAT=1 and RD_LAT=2 bridges, each on its own SRAM model.
module tb_wb_ram512x8_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  logic        cyc_s[2], stb_s[2], we_s[2], ack_s[2], wen_s[2];
  logic [6:0]  adr_s[2];
  logic [31:0] dw_s[2], dr_s[2];
  logic [3:0]  sel_s[2];
  logic [8:0]  radr_s[2];
  logic [7:0]  rdo_s[2], rdi_s[2], p1[2], p2[2];
  logic [7:0]  mem[2][512];
  logic [9:0]  wlog[$];
  typedef struct {int dev; bit rd; logic [31:0] dat; int at;} exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  logic [35:0] aseq;
  int n;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_ram512x8_bridge_if w();
    assign w.cyc = cyc_s[g];
    assign w.stb = stb_s[g];
    assign w.we = we_s[g];
    assign w.adr = adr_s[g];
    assign w.dat_w = dw_s[g];
    assign w.sel = sel_s[g];
    assign ack_s[g] = w.ack;
    assign dr_s[g] = w.dat_r;
    wb_ram512x8_bridge #(.RD_LAT(g + 1)) u_dut (
      .clk_i(clk), .rst_i(rst), .wb(w), .ram_wen_o(wen_s[g]),
      .ram_adr_o(radr_s[g]), .ram_dat_o(rdo_s[g]), .ram_dat_i(rdi_s[g]));
  end
  assign rdi_s[0] = p1[0];
  assign rdi_s[1] = p2[1];
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (wen_s[i]) begin
        mem[i][radr_s[i]] <= rdo_s[i];
        wlog.push_back({1'(i), radr_s[i]});
      end
      p1[i] <= mem[i][radr_s[i]];
      p2[i] <= p1[i];
    end
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endfunction
  // kill >= 0: abort (or reset if use_rst) in the cycle where cnt == kill; no ack expected.
  task automatic xfer(input int d, input bit we, input logic [6:0] a, input logic [31:0] dt,
                      input logic [3:0] sel, input logic [31:0] ex, input int kill,
                      input bit use_rst, input bit stb_drop, output logic [35:0] seq);
    int t0, lat;
    t0 = cyc_n;
    lat = d ? 7 : 6;
`ifdef WB_RAM_WSKIP_EN
    if (we) lat = sel == 4'd0 ? 1 : $countones(sel) + 2;
`endif
    seq = '0;
    cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = we; adr_s[d] = a; dw_s[d] = dt; sel_s[d] = sel;
    if (kill < 0) exp_q.push_back('{d, !we, ex, t0 + lat});
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == kill) begin
        if (use_rst) rst = 1'b1;
        else begin cyc_s[d] = 1'b0; stb_s[d] = 1'b0; end
        @(posedge clk); #1;
        rst = 1'b0; cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
        return;
      end
      if (stb_drop && c == 2) stb_s[d] = 1'b0;
      @(negedge clk);
      if (c < 4) seq[9*c +: 9] = radr_s[d];
      if (ack_s[d]) begin
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
    cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
  endtask
  task automatic wr(input int d, input logic [6:0] a, input logic [31:0] dt, input logic [3:0] sel);
    logic [35:0] s;
    xfer(d, 1'b1, a, dt, sel, 32'd0, -1, 1'b0, 1'b0, s);
  endtask
  task automatic rd(input int d, input logic [6:0] a, input logic [31:0] ex);
    logic [35:0] s;
    xfer(d, 1'b0, a, 32'd0, 4'hF, ex, -1, 1'b0, 1'b0, s);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      cyc_s[i] = 0; stb_s[i] = 0; we_s[i] = 0; adr_s[i] = 0; dw_s[i] = 0; sel_s[i] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++)
          if (ack_s[d]) begin
            exp_t e;
            if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack_s[d]), 32'd0);
            else begin
              e = exp_q.pop_front();
              chk("ack_dev", d, e.dev);
              chk("ack_cycle", cyc_n, e.at);
              if (e.rd) chk("rd_data", dr_s[d], e.dat);
            end
          end
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(ack_s[d]), 0);
      chk("rst_wen", 32'(wen_s[d]), 0);
      chk("rst_radr", 32'(radr_s[d]), 0);
      chk("rst_rdat_o", 32'(rdo_s[d]), 0);
      chk("rst_wb_dat", dr_s[d], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_ack", 32'(ack_s[0]), 0);
    wr(0, 7'h05, 32'hA1B2C3D4, 4'hF);
    chk("mem_14", 32'(mem[0][9'h014]), 32'hD4);
    chk("mem_15", 32'(mem[0][9'h015]), 32'hC3);
    chk("mem_16", 32'(mem[0][9'h016]), 32'hB2);
    chk("mem_17", 32'(mem[0][9'h017]), 32'hA1);
    rd(0, 7'h05, 32'hA1B2C3D4);
    n = wlog.size();
    wr(0, 7'h7F, 32'h11223344, 4'hF);
    chk("wrap_cnt", wlog.size(), n + 4);
    if (wlog.size() == n + 4) begin
      chk("wrap_a0", 32'(wlog[n]), 32'h1FC);
      chk("wrap_a1", 32'(wlog[n+1]), 32'h1FD);
      chk("wrap_a2", 32'(wlog[n+2]), 32'h1FE);
      chk("wrap_a3", 32'(wlog[n+3]), 32'h1FF);
    end
    n = wlog.size();
    wr(0, 7'h7F, 32'hFFFFFFFF, 4'b0101);
    chk("part_cnt", wlog.size(), n + 2);
    if (wlog.size() == n + 2) begin
      chk("part_a0", 32'(wlog[n]), 32'h1FC);
      chk("part_a1", 32'(wlog[n+1]), 32'h1FE);
    end
    rd(0, 7'h7F, 32'h11FF33FF);
    wr(0, 7'h00, 32'h03020100, 4'hF);
    xfer(0, 1'b0, 7'h00, 32'd0, 4'h0, 32'h03020100, -1, 1'b0, 1'b0, aseq);
    chk("rd0_adrseq", 32'(aseq), 32'({9'h003, 9'h002, 9'h001, 9'h000}));
    wr(0, 7'h10, 32'h00000000, 4'hF);
    n = wlog.size();
    xfer(0, 1'b1, 7'h10, 32'h55667788, 4'hF, 32'd0, 1, 1'b0, 1'b0, aseq);
    chk("abort_cnt", wlog.size(), n + 1);
    if (wlog.size() == n + 1) chk("abort_a0", 32'(wlog[n]), 32'h040);
    chk("abort_m40", 32'(mem[0][9'h040]), 32'h88);
    chk("abort_m41", 32'(mem[0][9'h041]), 32'h00);
    rd(0, 7'h10, 32'h00000088);
    xfer(0, 1'b0, 7'h05, 32'd0, 4'hF, 32'hA1B2C3D4, -1, 1'b0, 1'b1, aseq);
    wr(1, 7'h20, 32'hDEADBEEF, 4'hF);
    rd(1, 7'h20, 32'hDEADBEEF);
    xfer(1, 1'b0, 7'h20, 32'd0, 4'hF, 32'd0, 2, 1'b1, 1'b0, aseq);
    chk("rst_mid_dat", dr_s[1], 32'd0);
    rd(1, 7'h20, 32'hDEADBEEF);
    repeat (5) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
